// File: rtl/rr_grant_enc4.sv
// rtl/rr_grant_enc4.sv - four-way round-robin arbiter driving a 2-to-4 decoder select pair
module rr_grant_enc4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       a,
    output logic       b,
    output logic       gnt_valid,
    output logic       expired
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic       HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] idx;
    logic [7:0] hcnt;

    logic [1:0] pick;
    logic       any_req;
    logic       rel_drop;
    logic       rel_done;
    logic       rel_time;

    // Walk from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        pick    = ptr;
        any_req = |req;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                pick = ptr + 2'(k);
            end
        end
    end

    assign rel_drop = !req[idx];
    assign rel_done = done;
    assign rel_time = HOLD_EN && (hcnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            idx     <= 2'd0;
            hcnt    <= 8'd0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        idx   <= pick;
                        ptr   <= pick + 2'd1;
                        hcnt  <= 8'd0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_drop || rel_done || rel_time) begin
                        state   <= IDLE;
                        expired <= rel_time && !rel_drop && !rel_done;
                    end else if (hcnt != 8'hFF) begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is a flop or a direct decode of one, so the decoder never sees input glitches.
    assign a         = idx[1];
    assign b         = idx[0];
    assign gnt_valid = (state == GRANT);

endmodule
